// File: rtl/iic_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iic_cfg_pkg
// Brief    : Opcodes, table-entry layout and sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package iic_cfg_pkg;

    localparam int ENTRY_W        = 26;
    localparam int ENTRY_OP_LSB   = 24;
    localparam int ENTRY_ADDR_LSB = 8;
    localparam int ENTRY_DATA_LSB = 0;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_RDCHK = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_PWRUP  = 4'd1,
        ST_FETCH  = 4'd2,
        ST_ISSUE  = 4'd3,
        ST_WAIT_H = 4'd4,
        ST_WAIT_L = 4'd5,
        ST_DLY    = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERR    = 4'd8
    } cfg_state_e;

    function automatic logic [1:0] entry_op(input logic [ENTRY_W-1:0] e);
        return e[ENTRY_OP_LSB +: 2];
    endfunction

    function automatic logic [7:0] entry_data(input logic [ENTRY_W-1:0] e);
        return e[ENTRY_DATA_LSB +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/iic_cfg_lut.sv
`default_nettype none
// ============================================================================
// Module   : iic_cfg_lut
// Brief    : Combinational per-chip configuration ROM (index -> entry).
// Revision : 1.0 - initial release
// ============================================================================
module iic_cfg_lut
    import iic_cfg_pkg::*;
#(
    parameter int IDX_WIDTH = 8
) (
    input  logic [IDX_WIDTH-1:0] cfg_index,
    output logic [ENTRY_W-1:0]   cfg_entry
);

    // HDMI transmitter bring-up: power up, fixed registers, then verify power state.
    always_comb begin
        cfg_entry = {OP_END, 24'h000000};
        case (cfg_index)
            IDX_WIDTH'(0):  cfg_entry = {OP_WRITE, 16'h0041, 8'h10};
            IDX_WIDTH'(1):  cfg_entry = {OP_DELAY, 16'h0000, 8'd5};
            IDX_WIDTH'(2):  cfg_entry = {OP_WRITE, 16'h0098, 8'h03};
            IDX_WIDTH'(3):  cfg_entry = {OP_WRITE, 16'h009A, 8'hE0};
            IDX_WIDTH'(4):  cfg_entry = {OP_WRITE, 16'h009C, 8'h30};
            IDX_WIDTH'(5):  cfg_entry = {OP_WRITE, 16'h009D, 8'h61};
            IDX_WIDTH'(6):  cfg_entry = {OP_WRITE, 16'h00A2, 8'hA4};
            IDX_WIDTH'(7):  cfg_entry = {OP_WRITE, 16'h00A3, 8'hA4};
            IDX_WIDTH'(8):  cfg_entry = {OP_WRITE, 16'h00E0, 8'hD0};
            IDX_WIDTH'(9):  cfg_entry = {OP_WRITE, 16'h00AF, 8'h06};
            IDX_WIDTH'(10): cfg_entry = {OP_RDCHK, 16'h0041, 8'h10};
            default:        cfg_entry = {OP_END, 24'h000000};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/iic_cfg_sequencer_mstimer.sv
`default_nettype none
// ============================================================================
// Module   : iic_cfg_sequencer_mstimer
// Brief    : Restartable millisecond tick counter with a target-reached flag.
// Revision : 1.0 - initial release
// ============================================================================
module iic_cfg_sequencer_mstimer #(
    parameter int CLK_FRE = 50_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        restart,
    input  logic [15:0] target,
    output logic        expired
);

    localparam int c_TICK_CYCLES = (CLK_FRE / 1000 < 2) ? 2 : CLK_FRE / 1000;
    localparam int c_DIV_W       = $clog2(c_TICK_CYCLES);

    logic [c_DIV_W-1:0] r_div;
    logic [15:0]        r_ms;
    logic               w_tick;

    assign w_tick = (r_div == c_DIV_W'(c_TICK_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div <= '0;
            r_ms  <= '0;
        end else if (restart) begin
            r_div <= '0;
            r_ms  <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + c_DIV_W'(1);
            if (w_tick)
                r_ms <= r_ms + 16'd1;
        end
    end

    // Fires on the tick that completes the last millisecond, so n ms lasts n ticks.
    assign expired = (target == 16'd0) || (w_tick && (r_ms == target - 16'd1));

endmodule
`default_nettype wire

// File: rtl/iic_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : iic_cfg_sequencer
// Brief    : Table-driven I2C configuration sequencer feeding iic_tx_driver.
// Revision : 1.0 - initial release
// ============================================================================
module iic_cfg_sequencer
    import iic_cfg_pkg::*;
#(
    parameter int         CLK_FRE     = 50_000_000,
    parameter int         ADDR_BYTE   = 1,
    parameter int         IDX_WIDTH   = 8,
    parameter logic [7:0] DEVICE_ID   = 8'h72,
    parameter int         POWERUP_MS  = 10,
    parameter int         AUTO_START  = 1,
    parameter int         ACK_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cfg_start,
    output logic [IDX_WIDTH-1:0]   cfg_index,
    input  logic [ENTRY_W-1:0]     cfg_entry,
    output logic                   iic_pluse,
    output logic [7:0]             iic_device_id,
    output logic                   iic_w_r,
    output logic [3:0]             iic_byte_len,
    output logic [ADDR_BYTE*8-1:0] iic_addr,
    output logic [7:0]             iic_data_in,
    input  logic                   iic_busy,
    input  logic [7:0]             iic_data_out,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic [IDX_WIDTH-1:0]   err_index
);

    cfg_state_e           r_state;
    cfg_state_e           w_state_nxt;
    logic [ENTRY_W-1:0]   r_entry;
    logic [IDX_WIDTH-1:0] r_index;
    logic [IDX_WIDTH-1:0] r_err_index;
    logic                 r_done;
    logic                 r_err;
    logic                 r_auto;
    logic [15:0]          r_to_cnt;

    logic w_load_entry, w_index_clr, w_index_inc, w_status_clr;
    logic w_set_done, w_fail, w_abort, w_to_clr, w_to_inc;
    logic w_tmr_restart, w_tmr_expired, w_auto_clr;
    logic w_last, w_rd_miss;
    logic [15:0] w_tmr_target;
    logic w_unused_entry;

    assign w_last    = (r_index == {IDX_WIDTH{1'b1}});
    assign w_rd_miss = (entry_op(r_entry) == OP_RDCHK) && (iic_data_out != entry_data(r_entry));

    assign w_tmr_target = (r_state == ST_PWRUP) ? 16'(POWERUP_MS) : {8'd0, entry_data(r_entry)};

    iic_cfg_sequencer_mstimer #(
        .CLK_FRE (CLK_FRE)
    ) u_mstimer (
        .clk     (clk),
        .rstn    (rstn),
        .restart (w_tmr_restart),
        .target  (w_tmr_target),
        .expired (w_tmr_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_entry  = 1'b0;
        w_index_clr   = 1'b0;
        w_index_inc   = 1'b0;
        w_status_clr  = 1'b0;
        w_set_done    = 1'b0;
        w_fail        = 1'b0;
        w_abort       = 1'b0;
        w_to_clr      = 1'b0;
        w_to_inc      = 1'b0;
        w_tmr_restart = 1'b0;
        w_auto_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start || r_auto) begin
                    w_state_nxt   = ST_PWRUP;
                    w_status_clr  = 1'b1;
                    w_index_clr   = 1'b1;
                    w_tmr_restart = 1'b1;
                    w_auto_clr    = 1'b1;
                end
            end
            ST_PWRUP: begin
                if (w_tmr_expired)
                    w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_load_entry = 1'b1;
                case (entry_op(cfg_entry))
                    OP_WRITE, OP_RDCHK: w_state_nxt = ST_ISSUE;
                    OP_DELAY: begin
                        w_state_nxt   = ST_DLY;
                        w_tmr_restart = 1'b1;
                    end
                    default: w_state_nxt = ST_DONE;
                endcase
            end
            ST_ISSUE: begin
                w_to_clr    = 1'b1;
                w_state_nxt = ST_WAIT_H;
            end
            ST_WAIT_H: begin
                w_to_inc = 1'b1;
                // ISSUE plus ACK_TIMEOUT-1 cycles here gives ACK_TIMEOUT cycles of pluse.
                if (iic_busy)
                    w_state_nxt = ST_WAIT_L;
                else if (r_to_cnt == 16'(ACK_TIMEOUT - 2))
                    w_state_nxt = ST_ERR;
            end
            ST_WAIT_L: begin
                if (!iic_busy) begin
                    w_fail = w_rd_miss;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_index_inc = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DLY: begin
                if (w_tmr_expired) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_index_inc = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                w_set_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_fail      = 1'b1;
                w_abort     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_entry     <= '0;
            r_index     <= '0;
            r_err_index <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_auto      <= (AUTO_START != 0);
            r_to_cnt    <= '0;
        end else begin
            if (w_auto_clr)
                r_auto <= 1'b0;
            if (w_load_entry)
                r_entry <= cfg_entry;
            if (w_index_clr)
                r_index <= '0;
            else if (w_index_inc)
                r_index <= r_index + IDX_WIDTH'(1);
            if (w_to_clr)
                r_to_cnt <= '0;
            else if (w_to_inc)
                r_to_cnt <= r_to_cnt + 16'd1;
            if (w_status_clr) begin
                r_done      <= 1'b0;
                r_err       <= 1'b0;
                r_err_index <= '0;
            end else begin
                if (w_set_done)
                    r_done <= 1'b1;
                if (w_abort)
                    r_done <= 1'b0;
                // Only the first failing entry is recorded.
                if (w_fail) begin
                    r_err <= 1'b1;
                    if (!r_err)
                        r_err_index <= r_index;
                end
            end
        end
    end

    // Transfer fields come straight from the held entry, so they stay put for the whole transfer.
    assign iic_pluse      = (r_state == ST_ISSUE) || (r_state == ST_WAIT_H);
    assign iic_device_id  = DEVICE_ID;
    assign iic_byte_len   = 4'd1;
    assign iic_w_r        = (entry_op(r_entry) != OP_RDCHK);
    assign iic_addr       = r_entry[ENTRY_ADDR_LSB +: ADDR_BYTE*8];
    assign iic_data_in    = entry_data(r_entry);
    assign w_unused_entry = ^r_entry;

    assign cfg_index = r_index;
    assign cfg_busy  = (r_state != ST_IDLE);
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;
    assign err_index = r_err_index;

endmodule
`default_nettype wire

// File: tb/tb_iic_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_iic_cfg_sequencer
// Brief    : Directed and randomized bench with a driver bus model and table-walk reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iic_cfg_sequencer;

    logic        clk;
    logic        rstn;
    logic        cfg_start;
    logic [7:0]  cfg_index;
    logic [25:0] cfg_entry;
    logic        iic_pluse;
    logic [7:0]  iic_device_id;
    logic        iic_w_r;
    logic [3:0]  iic_byte_len;
    logic [7:0]  iic_addr;
    logic [7:0]  iic_data_in;
    logic        iic_busy;
    logic [7:0]  iic_data_out;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [7:0]  err_index;

    logic [25:0] tbl [0:255];
    logic [7:0]  rd_resp [0:255];
    logic [16:0] obs_q [$];
    logic [16:0] exp_q [$];
    logic [16:0] cap;
    int          rd_ptr, stab_err, busy_len, t_fall, last_gap, cyc;
    bit          bus_enable;
    int          n_checks, n_errors;
    logic        exp_done, exp_err;
    logic [7:0]  exp_eidx, exp_idx;

    assign cfg_entry = tbl[cfg_index];

    iic_cfg_sequencer #(
        .CLK_FRE     (1_000_000),
        .ADDR_BYTE   (1),
        .IDX_WIDTH   (8),
        .DEVICE_ID   (8'h72),
        .POWERUP_MS  (1),
        .AUTO_START  (1),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_start     (cfg_start),
        .cfg_index     (cfg_index),
        .cfg_entry     (cfg_entry),
        .iic_pluse     (iic_pluse),
        .iic_device_id (iic_device_id),
        .iic_w_r       (iic_w_r),
        .iic_byte_len  (iic_byte_len),
        .iic_addr      (iic_addr),
        .iic_data_in   (iic_data_in),
        .iic_busy      (iic_busy),
        .iic_data_out  (iic_data_out),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .err_index     (err_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Driver model: answers each pluse with busy after 2 cycles, held busy_len cycles.
    initial begin
        iic_busy     = 1'b0;
        iic_data_out = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (iic_pluse && bus_enable && rstn) begin
                cap = {iic_w_r, iic_addr, iic_data_in};
                obs_q.push_back(cap);
                if (t_fall >= 0) last_gap = cyc - t_fall;
                repeat (2) @(posedge clk);
                #1;
                if (!iic_w_r) begin
                    iic_data_out = rd_resp[rd_ptr];
                    rd_ptr++;
                end
                iic_busy = 1'b1;
                for (int k = 0; k < busy_len; k++) begin
                    @(posedge clk); #1;
                    if (rstn && ({iic_w_r, iic_addr, iic_data_in} !== cap)) stab_err++;
                end
                iic_busy = 1'b0;
                t_fall   = cyc;
            end
        end
    end

    initial begin
        #900_000;
        n_errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int v, input int lo, input int hi);
        n_checks++;
        assert (v >= lo && v <= hi) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, v, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic [25:0] ent(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        return {op, 8'h00, a, d};
    endfunction

    task automatic fill_end();
        for (int i = 0; i < 256; i++) tbl[i] = ent(2'b11, 8'h00, 8'h00);
    endtask

    task automatic prep();
        obs_q.delete();
        rd_ptr   = 0;
        stab_err = 0;
        t_fall   = -1;
        last_gap = -1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 cfg_start = 1'b1;
        @(posedge clk); #1 cfg_start = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (!cfg_busy && n < 30000) begin step(); n++; end
        while (cfg_busy && n < 30000) begin step(); n++; end
        check_range({tag, "_run_bound"}, n, 0, 29999);
    endtask

    // Walk the table as the specification describes: I2C entries produce one transfer each.
    task automatic run_model();
        int nrd = 0;
        exp_q.delete();
        exp_done = 1'b0; exp_err = 1'b0; exp_eidx = 8'd0; exp_idx = 8'd0;
        for (int i = 0; i < 256; i++) begin
            logic [1:0] op = tbl[i][25:24];
            logic [7:0] a  = tbl[i][15:8];
            logic [7:0] d  = tbl[i][7:0];
            if (op == 2'b11) begin
                exp_done = 1'b1; exp_idx = 8'(i);
                break;
            end
            if (op == 2'b00) exp_q.push_back({1'b1, a, d});
            if (op == 2'b01) begin
                exp_q.push_back({1'b0, a, d});
                if (rd_resp[nrd] != d && !exp_err) begin
                    exp_err = 1'b1; exp_eidx = 8'(i);
                end
                nrd++;
            end
            if (i == 255) begin
                exp_done = 1'b1; exp_idx = 8'd255;
            end
        end
    endtask

    task automatic compare_run(input string tag);
        run_model();
        check({tag, "_ntxn"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_txn%0d", tag, i), {15'd0, obs_q[i]}, {15'd0, exp_q[i]});
        check({tag, "_done"}, cfg_done, exp_done);
        check({tag, "_err"}, cfg_err, exp_err);
        check({tag, "_err_index"}, err_index, exp_eidx);
        check({tag, "_index"}, cfg_index, exp_idx);
        check({tag, "_stable"}, stab_err, 0);
    endtask

    initial begin
        int b, n, nrd, len;
        rstn = 1'b0; cfg_start = 1'b0; bus_enable = 1'b1; busy_len = 200;
        n_checks = 0; n_errors = 0;
        for (int i = 0; i < 256; i++) rd_resp[i] = 8'h00;
        prep();

        // Reset state, then the auto-started write table.
        fill_end();
        tbl[0] = ent(2'b00, 8'h12, 8'hA5);
        tbl[1] = ent(2'b00, 8'h13, 8'h5A);
        repeat (3) step();
        check("rst_pluse", iic_pluse, 0);
        check("rst_w_r", iic_w_r, 1);
        check("rst_addr", iic_addr, 0);
        check("rst_data_in", iic_data_in, 0);
        check("rst_index", cfg_index, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_err", cfg_err, 0);
        check("rst_err_index", err_index, 0);
        check("dev_id", iic_device_id, 8'h72);
        check("byte_len", iic_byte_len, 1);
        rstn = 1'b1;
        wait_run("write");
        compare_run("write");
        check("write_gap", last_gap, 2);

        // Read-and-compare: first matches, second mismatches but execution continues.
        prep(); fill_end(); busy_len = 20;
        tbl[0] = ent(2'b01, 8'h00, 8'h81);
        tbl[1] = ent(2'b01, 8'h01, 8'h00);
        rd_resp[0] = 8'h81; rd_resp[1] = 8'h7F;
        pulse_start();
        check("start_clears_done", cfg_done, 0);
        check("start_busy_rise", cfg_busy, 1);
        wait_run("rdchk");
        compare_run("rdchk");

        // Delay of 3 ms before the write; 1 ms power-up precedes FETCH of entry 0.
        prep(); fill_end();
        tbl[0] = ent(2'b10, 8'h00, 8'd3);
        tbl[1] = ent(2'b00, 8'h20, 8'h01);
        pulse_start();
        b = cyc; n = 0;
        while (!iic_pluse && n < 8000) begin step(); n++; end
        check_range("delay_pluse_time", cyc - b, 3997, 4003);
        wait_run("delay");
        compare_run("delay");

        // Acknowledge timeout: busy never rises.
        prep(); fill_end(); bus_enable = 1'b0;
        tbl[0] = ent(2'b00, 8'h30, 8'h11);
        pulse_start();
        n = 0;
        while (!iic_pluse && n < 3000) begin step(); n++; end
        check_range("to_pluse_seen", n, 0, 2999);
        n = 0;
        while (iic_pluse && n < 300) begin step(); n++; end
        check_range("to_pluse_len", n, 64, 65);
        wait_run("timeout");
        check("to_err", cfg_err, 1);
        check("to_err_index", err_index, 0);
        check("to_done", cfg_done, 0);
        check("to_busy", cfg_busy, 0);
        bus_enable = 1'b1;

        // Start pulses during an active run are ignored.
        prep(); fill_end();
        tbl[0] = ent(2'b00, 8'h50, 8'h01);
        tbl[1] = ent(2'b00, 8'h51, 8'h02);
        pulse_start();
        repeat (100) step();
        pulse_start();
        n = 0;
        while (!iic_pluse && n < 3000) begin step(); n++; end
        pulse_start();
        wait_run("ignore");
        repeat (20) step();
        check("ignore_no_restart", cfg_busy, 0);
        compare_run("ignore");

        // Reset while the driver is busy, then the auto-start rerun.
        prep(); fill_end(); busy_len = 200;
        tbl[0] = ent(2'b00, 8'h40, 8'h77);
        tbl[1] = ent(2'b00, 8'h41, 8'h88);
        pulse_start();
        n = 0;
        while (!(iic_busy && !iic_pluse) && n < 3000) begin step(); n++; end
        check_range("rst_wait_l_seen", n, 0, 2999);
        rstn = 1'b0;
        #1;
        check("rstmid_pluse", iic_pluse, 0);
        check("rstmid_busy", cfg_busy, 0);
        check("rstmid_index", cfg_index, 0);
        repeat (2) step();
        rstn = 1'b1;
        obs_q.delete();
        step();
        check("rerun_busy", cfg_busy, 1);
        check("rerun_index", cfg_index, 0);
        n = 0;
        while (iic_busy && n < 400) begin step(); n++; end
        stab_err = 0; busy_len = 20;
        wait_run("rerun");
        compare_run("rerun");

        // No END entry: the last index executes and the run finishes without wrapping.
        prep(); busy_len = 2;
        for (int i = 0; i < 256; i++) tbl[i] = ent(2'b00, 8'(i), 8'($urandom));
        pulse_start();
        wait_run("wrap");
        compare_run("wrap");

        // Randomized tables against the reference walk.
        for (int r = 0; r < 4; r++) begin
            prep(); fill_end();
            busy_len = $urandom_range(1, 20);
            len = $urandom_range(1, 10);
            nrd = 0;
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 2))
                    0: tbl[i] = ent(2'b00, 8'($urandom), 8'($urandom));
                    1: tbl[i] = ent(2'b01, 8'($urandom), 8'($urandom));
                    default: tbl[i] = ent(2'b10, 8'h00, 8'($urandom_range(0, 1)));
                endcase
                if (tbl[i][25:24] == 2'b01) begin
                    rd_resp[nrd] = ($urandom_range(0, 1) == 1) ? tbl[i][7:0] : 8'($urandom);
                    nrd++;
                end
            end
            pulse_start();
            wait_run($sformatf("rand%0d", r));
            compare_run($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
